issue_rat_fgr_ctrl: RTL and testbench
=====================================

ISSUE_RAT_FGR_CTRL -- requirements
Module: issue_rat_fgr_ctrl

Interface
REQ-001 SHALL have parameter FGR_MAX, default 7, maximum outstanding checkpoints (1..7).
REQ-002 SHALL have parameter ABANDON_CYCLES, default 2, recovery stall length after an abandon (1..15).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; state cleared while reset=0.
REQ-005 i_alloc_valid  input  1  rename requests a new checkpoint (FGR).
REQ-006 o_alloc_ready  output  1  allocation accepted when valid&ready.
REQ-007 o_alloc_fgr  output  3  tag granted on accepted allocation (current tail).
REQ-008 o_cur_fgr  output  3  tag for free-list acquires (youngest outstanding checkpoint).
REQ-009 o_cur_speculative  output  1  high when ≥1 checkpoint outstanding.
REQ-010 i_resolve_valid, i_resolve_fgr[2:0], i_resolve_mispredict  input  1/3/1  branch resolution of one tag.
REQ-011 o_commit_valid, o_commit_fgr[2:0]  output  1/3  commit pulse to free list.
REQ-012 o_abandon_valid, o_abandon_fgr[2:0]  output  1/3  abandon pulse to free list.
REQ-013 o_busy  output  1  high while in RECOVER.

Function
REQ-014 SHALL keep head (oldest), tail (next to allocate), count (0..FGR_MAX), 8-bit resolved vector; tags allocated in order, mod-8 wrap 7->0.
REQ-015 o_alloc_ready SHALL = (state==IDLE) & (count<FGR_MAX) & !(i_resolve_valid & i_resolve_mispredict).
REQ-016 accepted allocation: o_alloc_fgr=tail; next edge tail+1, count+1, resolved[tail]=0.
REQ-017 o_cur_fgr SHALL = tail-1 mod 8; o_cur_speculative = (count!=0).
REQ-018 tag T is outstanding iff (T-head) mod 8 < count; resolutions of non-outstanding tags SHALL be ignored.
REQ-019 correct resolve (mispredict=0) of outstanding T: resolved[T]=1 at next edge.
REQ-020 commit: when state==IDLE, count!=0, resolved[head]=1: o_commit_valid=1, o_commit_fgr=head combinationally; at that edge head+1, count-1, resolved[head]=0; max one commit/cycle; first commit one cycle after resolving edge.
REQ-021 mispredict on outstanding T (state IDLE): next cycle o_abandon_valid=1, o_abandon_fgr=T (registered pulse); tail:=T, count:=(T-head) mod 8, resolved bits of T..old tail-1 cleared, state:=RECOVER.
REQ-022 RECOVER SHALL last ABANDON_CYCLES cycles (counter), then IDLE; alloc, commit and all resolutions ignored during RECOVER.
REQ-023 simultaneous commit of head and mispredict on T: if T==head commit suppressed, abandon only; else both act (count reflects both).
REQ-024 alloc and correct resolve same cycle SHALL both act; alloc+commit same cycle leaves count unchanged.
REQ-025 count==FGR_MAX: o_alloc_ready=0; count==0: no commit, o_cur_speculative=0.

Reset
REQ-026 reset=0 SHALL immediately force head=tail=count=0, resolved=0, state IDLE, recovery counter 0, o_commit_valid=o_abandon_valid=o_busy=0.
REQ-027 after reset release o_alloc_ready=1, o_cur_fgr=7, o_cur_speculative=0; reset mid-RECOVER aborts recovery without pulses.

Configuration
REQ-028 macro ISSUE_RAT_FGR_CTRL_ABANDON_WALK_EN defined: abandon SHALL emit one o_abandon_valid pulse per discarded tag, youngest first (old tail-1 down to T), one per cycle, RECOVER lasting exactly that many cycles, ABANDON_CYCLES unused.
REQ-029 macro undefined: single abandon pulse for T and fixed ABANDON_CYCLES recovery per REQ-021/022.

Verification
REQ-030 reset, 3 allocs -> o_alloc_fgr 0,1,2; count 3; o_cur_fgr=2; o_cur_speculative=1.
REQ-031 7 allocs (FGR_MAX=7) -> o_alloc_ready=0 on 8th; resolve tag 0 correct -> commit fgr 0 next cycle, ready returns.
REQ-032 resolve tags 2 then 1 then 0 correct -> commits 0,1,2 on consecutive cycles after tag 0 resolves.
REQ-033 tags 0..4 outstanding, mispredict tag 2 -> abandon fgr 2 next cycle, o_busy 2 cycles, next alloc gets fgr 2; with WALK_EN abandons 4,3,2 over 3 cycles.
REQ-034 head=6, allocate 4 -> tags 6,7,0,1; commit all -> head=2, count 0, wrap verified.
REQ-035 reset asserted mid-RECOVER -> outputs zeroed same cycle, no further abandon pulses, ready=1 after release.

Source files
------------

// File: rtl/issue_rat_fgr_ctrl.sv
// Checkpoint (FGR) tag controller for the rename map: in-order tag allocation, in-order commit, abandon on mispredict.
// Optional ISSUE_RAT_FGR_CTRL_ABANDON_WALK_EN: abandon pulses every discarded tag, youngest first, one per RECOVER cycle.
module issue_rat_fgr_ctrl #(
    parameter int FGR_MAX        = 7,
    parameter int ABANDON_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_alloc_valid,
    output logic       o_alloc_ready,
    output logic [2:0] o_alloc_fgr,
    output logic [2:0] o_cur_fgr,
    output logic       o_cur_speculative,
    input  logic       i_resolve_valid,
    input  logic [2:0] i_resolve_fgr,
    input  logic       i_resolve_mispredict,
    output logic       o_commit_valid,
    output logic [2:0] o_commit_fgr,
    output logic       o_abandon_valid,
    output logic [2:0] o_abandon_fgr,
    output logic       o_busy
);

    typedef enum logic {IDLE, RECOVER} state_t;

    state_t     state, state_next;
    logic [2:0] head, tail;
    logic [3:0] count;
    logic [7:0] resolved, resolved_next;
    logic [3:0] rec_cnt, rec_next;
    logic       abandon_valid_q;
    logic [2:0] abandon_fgr_q;

    logic [2:0] res_dist;
    logic [3:0] discard_cnt;
    logic       res_hit, mispredict_fire, correct_fire;
    logic       commit_fire, alloc_fire;

    // A resolution only counts when its tag lies inside the head..tail window.
    assign res_dist        = i_resolve_fgr - head;
    assign discard_cnt     = count - {1'b0, res_dist};
    assign res_hit         = i_resolve_valid && (state == IDLE) && ({1'b0, res_dist} < count);
    assign mispredict_fire = res_hit && i_resolve_mispredict;
    assign correct_fire    = res_hit && !i_resolve_mispredict;

    assign o_alloc_ready = (state == IDLE) && (count < 4'(FGR_MAX))
                           && !(i_resolve_valid && i_resolve_mispredict);
    assign alloc_fire    = i_alloc_valid && o_alloc_ready;

    // A mispredict on the head itself discards it, so it must not also commit.
    assign commit_fire = (state == IDLE) && (count != 4'd0) && resolved[head]
                         && !(mispredict_fire && (i_resolve_fgr == head));

    assign o_commit_valid    = commit_fire;
    assign o_commit_fgr      = head;
    assign o_alloc_fgr       = tail;
    assign o_cur_fgr         = tail - 3'd1;
    assign o_cur_speculative = (count != 4'd0);
    assign o_abandon_valid   = abandon_valid_q;
    assign o_abandon_fgr     = abandon_fgr_q;
    assign o_busy            = (state == RECOVER);

    always_comb begin
        state_next = state;
        rec_next   = rec_cnt;
        case (state)
            IDLE: begin
                if (mispredict_fire) begin
                    state_next = RECOVER;
`ifdef ISSUE_RAT_FGR_CTRL_ABANDON_WALK_EN
                    rec_next   = discard_cnt - 4'd1;
`else
                    rec_next   = 4'(ABANDON_CYCLES - 1);
`endif
                end
            end
            RECOVER: begin
                if (rec_cnt == 4'd0) state_next = IDLE;
                else                 rec_next   = rec_cnt - 4'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Later writes win: alloc/commit clears override a same-cycle resolve.
    always_comb begin
        resolved_next = resolved;
        if (correct_fire) resolved_next[i_resolve_fgr] = 1'b1;
        if (alloc_fire)   resolved_next[tail] = 1'b0;
        if (commit_fire)  resolved_next[head] = 1'b0;
        if (mispredict_fire) begin
            for (int i = 0; i < 8; i++) begin
                if ({1'b0, 3'(i) - i_resolve_fgr} < discard_cnt) resolved_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rec_cnt  <= 4'd0;
            resolved <= 8'd0;
            head     <= 3'd0;
            tail     <= 3'd0;
            count    <= 4'd0;
        end else begin
            state    <= state_next;
            rec_cnt  <= rec_next;
            resolved <= resolved_next;
            head     <= head + {2'b0, commit_fire};
            if (mispredict_fire) begin
                tail  <= i_resolve_fgr;
                count <= {1'b0, res_dist} - {3'b0, commit_fire};
            end else begin
                tail  <= tail + {2'b0, alloc_fire};
                count <= count + {3'b0, alloc_fire} - {3'b0, commit_fire};
            end
        end
    end

    // Abandon pulse is registered so it lands one cycle after the mispredict edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            abandon_valid_q <= 1'b0;
            abandon_fgr_q   <= 3'd0;
        end else begin
`ifdef ISSUE_RAT_FGR_CTRL_ABANDON_WALK_EN
            if (mispredict_fire) begin
                abandon_valid_q <= 1'b1;
                abandon_fgr_q   <= tail - 3'd1;
            end else if (state == RECOVER) begin
                if (rec_cnt == 4'd0) abandon_valid_q <= 1'b0;
                else                 abandon_fgr_q   <= abandon_fgr_q - 3'd1;
            end
`else
            abandon_valid_q <= mispredict_fire;
            if (mispredict_fire) abandon_fgr_q <= i_resolve_fgr;
`endif
        end
    end

endmodule

// File: tb/tb_issue_rat_fgr_ctrl.sv
// Directed self-checking bench for issue_rat_fgr_ctrl (FGR_MAX=7, ABANDON_CYCLES=2).
module tb_issue_rat_fgr_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_alloc_valid;
    logic       o_alloc_ready;
    logic [2:0] o_alloc_fgr;
    logic [2:0] o_cur_fgr;
    logic       o_cur_speculative;
    logic       i_resolve_valid;
    logic [2:0] i_resolve_fgr;
    logic       i_resolve_mispredict;
    logic       o_commit_valid;
    logic [2:0] o_commit_fgr;
    logic       o_abandon_valid;
    logic [2:0] o_abandon_fgr;
    logic       o_busy;

    int checks   = 0;
    int failures = 0;

    issue_rat_fgr_ctrl #(.FGR_MAX(7), .ABANDON_CYCLES(2)) dut (
        .clk                 (clk),
        .reset               (reset),
        .i_alloc_valid       (i_alloc_valid),
        .o_alloc_ready       (o_alloc_ready),
        .o_alloc_fgr         (o_alloc_fgr),
        .o_cur_fgr           (o_cur_fgr),
        .o_cur_speculative   (o_cur_speculative),
        .i_resolve_valid     (i_resolve_valid),
        .i_resolve_fgr       (i_resolve_fgr),
        .i_resolve_mispredict(i_resolve_mispredict),
        .o_commit_valid      (o_commit_valid),
        .o_commit_fgr        (o_commit_fgr),
        .o_abandon_valid     (o_abandon_valid),
        .o_abandon_fgr       (o_abandon_fgr),
        .o_busy              (o_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic alloc, input logic rv, input logic [2:0] rfgr, input logic rmp);
        i_alloc_valid        = alloc;
        i_resolve_valid      = rv;
        i_resolve_fgr        = rfgr;
        i_resolve_mispredict = rmp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        #3;
        checkOutput("rst_commit",  32'(o_commit_valid), 32'd0);
        checkOutput("rst_abandon", 32'(o_abandon_valid), 32'd0);
        checkOutput("rst_busy",    32'(o_busy), 32'd0);
        checkOutput("rst_spec",    32'(o_cur_speculative), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("post_rst_ready",   32'(o_alloc_ready), 32'd1);
        checkOutput("post_rst_cur_fgr", 32'(o_cur_fgr), 32'd7);

        // Fill all seven checkpoints in order
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
            #1;
            checkOutput($sformatf("alloc_ready_%0d", i), 32'(o_alloc_ready), 32'd1);
            checkOutput($sformatf("alloc_fgr_%0d", i), 32'(o_alloc_fgr), 32'(i));
            tick();
            if (i == 2) begin
                checkOutput("three_cur_fgr", 32'(o_cur_fgr), 32'd2);
                checkOutput("three_spec",    32'(o_cur_speculative), 32'd1);
            end
        end
        #1;
        checkOutput("full_ready", 32'(o_alloc_ready), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        #1;
        checkOutput("full_cur_fgr", 32'(o_cur_fgr), 32'd6);

        // Resolve head 0 -> commit next cycle, ready returns after it
        applyStimulus(1'b0, 1'b1, 3'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        #1;
        checkOutput("commit0_valid", 32'(o_commit_valid), 32'd1);
        checkOutput("commit0_fgr",   32'(o_commit_fgr), 32'd0);
        checkOutput("commit0_ready", 32'(o_alloc_ready), 32'd0);
        tick();
        checkOutput("after_commit0_valid", 32'(o_commit_valid), 32'd0);
        checkOutput("after_commit0_ready", 32'(o_alloc_ready), 32'd1);

        // Out-of-order resolves 3,2,1 -> commits 1,2,3 back to back
        applyStimulus(1'b0, 1'b1, 3'd3, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 3'd2, 1'b0);
        #1;
        checkOutput("ooo_no_commit_a", 32'(o_commit_valid), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 3'd1, 1'b0);
        #1;
        checkOutput("ooo_no_commit_b", 32'(o_commit_valid), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        #1;
        checkOutput("ooo_commit1", 32'({o_commit_valid, o_commit_fgr}), 32'h9);
        tick();
        checkOutput("ooo_commit2", 32'({o_commit_valid, o_commit_fgr}), 32'hA);
        tick();
        checkOutput("ooo_commit3", 32'({o_commit_valid, o_commit_fgr}), 32'hB);
        tick();
        checkOutput("ooo_commit_done", 32'(o_commit_valid), 32'd0);

        // Outstanding 4,5,6: mispredict 5
        applyStimulus(1'b0, 1'b1, 3'd5, 1'b1);
        #1;
        checkOutput("mp_ready_low", 32'(o_alloc_ready), 32'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        #1;
`ifdef ISSUE_RAT_FGR_CTRL_ABANDON_WALK_EN
        checkOutput("mp5_abandon_a", 32'({o_abandon_valid, o_abandon_fgr}), 32'hE);
`else
        checkOutput("mp5_abandon_a", 32'({o_abandon_valid, o_abandon_fgr}), 32'hD);
`endif
        checkOutput("mp5_busy_a",  32'(o_busy), 32'd1);
        checkOutput("mp5_ready_a", 32'(o_alloc_ready), 32'd0);
        tick();
`ifdef ISSUE_RAT_FGR_CTRL_ABANDON_WALK_EN
        checkOutput("mp5_abandon_b", 32'({o_abandon_valid, o_abandon_fgr}), 32'hD);
`else
        checkOutput("mp5_abandon_b", 32'(o_abandon_valid), 32'd0);
`endif
        checkOutput("mp5_busy_b", 32'(o_busy), 32'd1);
        tick();
        checkOutput("mp5_busy_end",  32'(o_busy), 32'd0);
        checkOutput("mp5_abandon_end", 32'(o_abandon_valid), 32'd0);
        checkOutput("mp5_ready_end", 32'(o_alloc_ready), 32'd1);
        checkOutput("mp5_realloc",   32'(o_alloc_fgr), 32'd5);
        checkOutput("mp5_cur_fgr",   32'(o_cur_fgr), 32'd4);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        #1;
        checkOutput("realloc_cur_fgr", 32'(o_cur_fgr), 32'd5);

        // Outstanding 4,5: resolve 4, then mispredict 4 while it is committing
        applyStimulus(1'b0, 1'b1, 3'd4, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        #1;
        checkOutput("head_commit_pending", 32'({o_commit_valid, o_commit_fgr}), 32'hC);
        applyStimulus(1'b0, 1'b1, 3'd4, 1'b1);
        #1;
        checkOutput("head_mp_suppress", 32'(o_commit_valid), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        #1;
`ifdef ISSUE_RAT_FGR_CTRL_ABANDON_WALK_EN
        checkOutput("mp4_abandon_a", 32'({o_abandon_valid, o_abandon_fgr}), 32'hD);
`else
        checkOutput("mp4_abandon_a", 32'({o_abandon_valid, o_abandon_fgr}), 32'hC);
`endif
        checkOutput("mp4_spec",    32'(o_cur_speculative), 32'd0);
        checkOutput("mp4_cur_fgr", 32'(o_cur_fgr), 32'd3);
        tick();
`ifdef ISSUE_RAT_FGR_CTRL_ABANDON_WALK_EN
        checkOutput("mp4_abandon_b", 32'({o_abandon_valid, o_abandon_fgr}), 32'hC);
`else
        checkOutput("mp4_abandon_b", 32'(o_abandon_valid), 32'd0);
`endif
        checkOutput("mp4_busy_b", 32'(o_busy), 32'd1);
        tick();
        checkOutput("mp4_busy_end", 32'(o_busy), 32'd0);
        checkOutput("empty_no_commit", 32'(o_commit_valid), 32'd0);

        // Move head to 6 through allocate/commit of 4,5
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b1, 3'd4, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 3'd5, 1'b0);
        #1;
        checkOutput("pre_wrap_commit4", 32'({o_commit_valid, o_commit_fgr}), 32'hC);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        #1;
        checkOutput("pre_wrap_commit5", 32'({o_commit_valid, o_commit_fgr}), 32'hD);
        tick();
        checkOutput("pre_wrap_spec", 32'(o_cur_speculative), 32'd0);

        // Wrap: tags 6,7,0,1; last alloc shares its cycle with resolve 6
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, (i == 3), 3'd6, 1'b0);
            #1;
            checkOutput($sformatf("wrap_alloc_%0d", i), 32'(o_alloc_fgr), 32'((6 + i) % 8));
            tick();
        end
        applyStimulus(1'b0, 1'b1, 3'd7, 1'b0);
        #1;
        checkOutput("wrap_commit6", 32'({o_commit_valid, o_commit_fgr}), 32'hE);
        checkOutput("wrap_cur_fgr", 32'(o_cur_fgr), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b1, 3'd0, 1'b0);
        #1;
        checkOutput("wrap_commit7", 32'({o_commit_valid, o_commit_fgr}), 32'hF);
        tick();
        applyStimulus(1'b0, 1'b1, 3'd1, 1'b0);
        #1;
        checkOutput("wrap_commit0", 32'({o_commit_valid, o_commit_fgr}), 32'h8);
        tick();
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        #1;
        checkOutput("wrap_commit1",    32'({o_commit_valid, o_commit_fgr}), 32'h9);
        checkOutput("alloc_with_commit", 32'(o_alloc_fgr), 32'd2);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        #1;
        checkOutput("after_wrap_commit", 32'(o_commit_valid), 32'd0);
        checkOutput("after_wrap_spec",   32'(o_cur_speculative), 32'd1);
        checkOutput("after_wrap_cur",    32'(o_cur_fgr), 32'd2);

        // Mispredict of a tag outside the window is ignored
        applyStimulus(1'b0, 1'b1, 3'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        #1;
        checkOutput("stale_mp_abandon", 32'(o_abandon_valid), 32'd0);
        checkOutput("stale_mp_busy",    32'(o_busy), 32'd0);

        // Reset in the middle of recovery
        applyStimulus(1'b0, 1'b1, 3'd2, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        #1;
        checkOutput("mp2_abandon", 32'({o_abandon_valid, o_abandon_fgr}), 32'hA);
        checkOutput("mp2_busy",    32'(o_busy), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("midrec_rst_abandon", 32'(o_abandon_valid), 32'd0);
        checkOutput("midrec_rst_busy",    32'(o_busy), 32'd0);
        checkOutput("midrec_rst_commit",  32'(o_commit_valid), 32'd0);
        tick();
        reset = 1'b1;
        #1;
        checkOutput("midrec_rel_ready", 32'(o_alloc_ready), 32'd1);
        checkOutput("midrec_rel_cur",   32'(o_cur_fgr), 32'd7);
        checkOutput("midrec_rel_spec",  32'(o_cur_speculative), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("midrec_quiet_%0d", i), 32'({o_abandon_valid, o_busy}), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
